// File: rtl/ocrom_port_arbiter_if.sv
// Bus bundle between the fetch/debug masters, the arbiter and the instruction memory s1 port.
// The slave modport is the arbiter's view; master is the surrounding system (masters plus memory).
interface ocrom_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
);
    logic              reset_req;

    logic [ADDR_W-1:0] f_address;
    logic              f_read;
    logic              f_waitrequest;
    logic [DATA_W-1:0] f_readdata;
    logic              f_readdatavalid;

    logic [ADDR_W-1:0] d_address;
    logic              d_read;
    logic              d_write;
    logic [DATA_W-1:0] d_writedata;
    logic [BE_W-1:0]   d_byteenable;
    logic              d_waitrequest;
    logic [DATA_W-1:0] d_readdata;
    logic              d_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_debugaccess;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  reset_req,
        input  f_address, f_read,
        output f_waitrequest, f_readdata, f_readdatavalid,
        input  d_address, d_read, d_write, d_writedata, d_byteenable,
        output d_waitrequest, d_readdata, d_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_debugaccess, mem_clken,
        input  mem_readdata
    );

    modport master (
        output reset_req,
        output f_address, f_read,
        input  f_waitrequest, f_readdata, f_readdatavalid,
        output d_address, d_read, d_write, d_writedata, d_byteenable,
        input  d_waitrequest, d_readdata, d_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_debugaccess, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/ocrom_port_arbiter.sv
// Round-robin arbiter sharing one instruction memory port between fetch (read) and debug (read/write).
// Latency: command issued in grant cycle, read data valid exactly one cycle later.
// Backpressure: losing or blocked (reset/reset_req) requester sees waitrequest=1 and must hold.
module ocrom_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int BE_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ocrom_port_arbiter_if.slave   bus
);

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DEBUG = 1'b1
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              cs;
        logic              wr;
    } mem_cmd_t;

    grant_e            last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic              rv_f;
    logic              rv_d;

    logic              f_req;
    logic              d_req;
    logic              blocked;
    logic              grant_f;
    logic              grant_d;
    mem_cmd_t          cmd;

    assign f_req   = bus.f_read;
    assign d_req   = bus.d_read | bus.d_write;
    assign blocked = reset | bus.reset_req;

    // On contention the master that did not win last time goes next.
    assign grant_f = ~blocked & f_req & (~d_req | (last_grant == GRANT_DEBUG));
    assign grant_d = ~blocked & d_req & (~f_req | (last_grant == GRANT_FETCH));

    always_comb begin
        cmd      = '0;
        cmd.addr = addr_q;
        if (grant_f) begin
            cmd.addr = bus.f_address;
            cmd.be   = '1;
            cmd.cs   = 1'b1;
        end else if (grant_d) begin
            cmd.addr  = bus.d_address;
            cmd.be    = bus.d_byteenable;
            cmd.wdata = bus.d_writedata;
            cmd.cs    = 1'b1;
            cmd.wr    = bus.d_write;
        end
    end

    assign bus.mem_address     = cmd.addr;
    assign bus.mem_byteenable  = cmd.be;
    assign bus.mem_writedata   = cmd.wdata;
    assign bus.mem_chipselect  = cmd.cs;
    assign bus.mem_write       = cmd.wr;
    assign bus.mem_debugaccess = cmd.wr;
    assign bus.mem_clken       = ~bus.reset_req;

    assign bus.f_waitrequest   = ~grant_f;
    assign bus.d_waitrequest   = ~grant_d;

    // Readdata is shared; each consumer qualifies it with its own valid.
    assign bus.f_readdata      = bus.mem_readdata;
    assign bus.d_readdata      = bus.mem_readdata;
    assign bus.f_readdatavalid = rv_f;
    assign bus.d_readdatavalid = rv_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GRANT_DEBUG;
            addr_q     <= '0;
            rv_f       <= 1'b0;
            rv_d       <= 1'b0;
        end else begin
            if (grant_f) begin
                last_grant <= GRANT_FETCH;
                addr_q     <= bus.f_address;
            end else if (grant_d) begin
                last_grant <= GRANT_DEBUG;
                addr_q     <= bus.d_address;
            end
            rv_f <= grant_f;
            rv_d <= grant_d & ~bus.d_write;
        end
    end

endmodule

// File: tb/tb_ocrom_port_arbiter.sv
// Directed bench for ocrom_port_arbiter with a behavioural 2048x16 memory behind the s1 side.
module tb_ocrom_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    ocrom_port_arbiter_if #(.ADDR_W(11), .DATA_W(16), .BE_W(2)) bus ();

    ocrom_port_arbiter #(.ADDR_W(11), .DATA_W(16), .BE_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:2047];

    function automatic logic [15:0] rom_word(input int a);
        return 16'hA000 ^ 16'(a);
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = rom_word(i);
    end

    // Single-port memory, one-cycle registered read, clock-enable gated.
    always @(posedge clk) begin
        if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) begin
                if (bus.mem_byteenable[0]) mem[bus.mem_address][7:0]  <= bus.mem_writedata[7:0];
                if (bus.mem_byteenable[1]) mem[bus.mem_address][15:8] <= bus.mem_writedata[15:8];
            end else begin
                bus.mem_readdata <= mem[bus.mem_address];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.f_read    = 1'b0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.reset_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.f_address = '0; bus.d_address = '0; bus.d_writedata = '0; bus.d_byteenable = 2'b11;
        bus.f_read = 1'b1;
        tick();
        #1;
        total++; if (bus.f_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_fwait_blocked got=%b want=1", bus.f_waitrequest); end
        total++; if (bus.mem_chipselect !== 1'b0) begin bad++; $display("FAIL rst_cs_blocked got=%b want=0", bus.mem_chipselect); end
        bus.f_read = 1'b0;
        tick();
        total++; if (bus.f_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_frdv got=%b want=0", bus.f_readdatavalid); end
        total++; if (bus.d_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_drdv got=%b want=0", bus.d_readdatavalid); end
        total++; if (bus.d_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_dwait got=%b want=1", bus.d_waitrequest); end
        total++; if (bus.mem_write !== 1'b0 || bus.mem_debugaccess !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b%b want=00", bus.mem_write, bus.mem_debugaccess); end
        total++; if (bus.mem_address !== 11'h000) begin bad++; $display("FAIL rst_addr got=%h want=000", bus.mem_address); end
        total++; if (bus.mem_clken !== 1'b1) begin bad++; $display("FAIL rst_clken got=%b want=1", bus.mem_clken); end
        reset = 1'b0;
    endtask

    task automatic test_fetch_stream();
        for (int k = 0; k < 8; k++) begin
            bus.f_read    = 1'b1;
            bus.f_address = 11'(k);
            #1;
            total++; if (bus.f_waitrequest !== 1'b0) begin bad++; $display("FAIL stream_fwait k=%0d got=%b want=0", k, bus.f_waitrequest); end
            total++; if (bus.mem_address !== 11'(k) || bus.mem_chipselect !== 1'b1 || bus.mem_byteenable !== 2'b11) begin bad++; $display("FAIL stream_cmd k=%0d got=%h/%b/%b want=%h/1/11", k, bus.mem_address, bus.mem_chipselect, bus.mem_byteenable, 11'(k)); end
            tick();
            total++; if (bus.f_readdatavalid !== 1'b1 || bus.f_readdata !== rom_word(k)) begin bad++; $display("FAIL stream_data k=%0d got=%b/%h want=1/%h", k, bus.f_readdatavalid, bus.f_readdata, rom_word(k)); end
            total++; if (bus.d_readdatavalid !== 1'b0) begin bad++; $display("FAIL stream_drdv k=%0d got=%b want=0", k, bus.d_readdatavalid); end
        end
        bus.f_read = 1'b0;
        #1;
        total++; if (bus.f_waitrequest !== 1'b1) begin bad++; $display("FAIL stream_idle_wait got=%b want=1", bus.f_waitrequest); end
        tick();
        total++; if (bus.f_readdatavalid !== 1'b0) begin bad++; $display("FAIL stream_tail_rdv got=%b want=0", bus.f_readdatavalid); end
    endtask

    task automatic test_debug_write_read();
        bus.d_write = 1'b1; bus.d_address = 11'h123; bus.d_writedata = 16'hBEEF; bus.d_byteenable = 2'b11;
        #1;
        total++; if (bus.d_waitrequest !== 1'b0 || bus.f_waitrequest !== 1'b1) begin bad++; $display("FAIL dwr_wait got=%b/%b want=0/1", bus.d_waitrequest, bus.f_waitrequest); end
        total++; if (bus.mem_write !== 1'b1 || bus.mem_debugaccess !== 1'b1) begin bad++; $display("FAIL dwr_dbgacc got=%b%b want=11", bus.mem_write, bus.mem_debugaccess); end
        total++; if (bus.mem_writedata !== 16'hBEEF || bus.mem_address !== 11'h123) begin bad++; $display("FAIL dwr_bus got=%h@%h want=BEEF@123", bus.mem_writedata, bus.mem_address); end
        tick();
        total++; if (bus.d_readdatavalid !== 1'b0) begin bad++; $display("FAIL dwr_no_rdv got=%b want=0", bus.d_readdatavalid); end
        bus.d_write = 1'b0; bus.d_read = 1'b1;
        #1;
        total++; if (bus.mem_debugaccess !== 1'b0 || bus.mem_write !== 1'b0 || bus.d_waitrequest !== 1'b0) begin bad++; $display("FAIL drd_cmd got=%b%b%b want=000", bus.mem_debugaccess, bus.mem_write, bus.d_waitrequest); end
        tick();
        bus.d_read = 1'b0;
        total++; if (bus.d_readdatavalid !== 1'b1 || bus.d_readdata !== 16'hBEEF) begin bad++; $display("FAIL drd_data got=%b/%h want=1/BEEF", bus.d_readdatavalid, bus.d_readdata); end
        total++; if (bus.f_readdatavalid !== 1'b0) begin bad++; $display("FAIL drd_cross got=%b want=0", bus.f_readdatavalid); end
        tick();
        total++; if (bus.d_readdatavalid !== 1'b0) begin bad++; $display("FAIL drd_once got=%b want=0", bus.d_readdatavalid); end
    endtask

    task automatic test_byte_write();
        bus.d_write = 1'b1; bus.d_address = 11'h010; bus.d_writedata = 16'h5566; bus.d_byteenable = 2'b11;
        tick();
        bus.d_writedata = 16'h12AB; bus.d_byteenable = 2'b01;
        #1;
        total++; if (bus.mem_byteenable !== 2'b01) begin bad++; $display("FAIL bw_be got=%b want=01", bus.mem_byteenable); end
        tick();
        bus.d_write = 1'b0; bus.d_read = 1'b1;
        tick();
        bus.d_read = 1'b0;
        total++; if (bus.d_readdatavalid !== 1'b1 || bus.d_readdata !== 16'h55AB) begin bad++; $display("FAIL bw_data got=%b/%h want=1/55AB", bus.d_readdatavalid, bus.d_readdata); end
        tick();
    endtask

    task automatic test_contention();
        reset = 1'b1; idle_inputs();
        tick();
        reset = 1'b0;
        bus.f_read = 1'b1; bus.f_address = 11'h004;
        bus.d_read = 1'b1; bus.d_address = 11'h123;
        for (int i = 0; i < 6; i++) begin
            logic gf;
            gf = (i % 2 == 0);
            #1;
            total++; if (bus.f_waitrequest !== !gf || bus.d_waitrequest !== gf) begin bad++; $display("FAIL cont_wait i=%0d got=%b/%b want=%b/%b", i, bus.f_waitrequest, bus.d_waitrequest, !gf, gf); end
            total++; if (bus.mem_address !== (gf ? 11'h004 : 11'h123)) begin bad++; $display("FAIL cont_addr i=%0d got=%h want=%h", i, bus.mem_address, gf ? 11'h004 : 11'h123); end
            tick();
            total++; if (bus.f_readdatavalid !== gf || bus.d_readdatavalid !== !gf) begin bad++; $display("FAIL cont_rdv i=%0d got=%b/%b want=%b/%b", i, bus.f_readdatavalid, bus.d_readdatavalid, gf, !gf); end
            total++; if (bus.f_readdata !== (gf ? rom_word(4) : 16'hBEEF)) begin bad++; $display("FAIL cont_data i=%0d got=%h want=%h", i, bus.f_readdata, gf ? rom_word(4) : 16'hBEEF); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_req();
        reset = 1'b1; idle_inputs();
        tick();
        reset = 1'b0;
        bus.f_read = 1'b1; bus.f_address = 11'h004;
        bus.d_read = 1'b1; bus.d_address = 11'h123;
        #1;
        total++; if (bus.f_waitrequest !== 1'b0) begin bad++; $display("FAIL rr_first_f got=%b want=0", bus.f_waitrequest); end
        tick();
        #1;
        total++; if (bus.d_waitrequest !== 1'b0) begin bad++; $display("FAIL rr_second_d got=%b want=0", bus.d_waitrequest); end
        tick();
        bus.reset_req = 1'b1;
        total++; if (bus.d_readdatavalid !== 1'b1 || bus.d_readdata !== 16'hBEEF) begin bad++; $display("FAIL rr_inflight got=%b/%h want=1/BEEF", bus.d_readdatavalid, bus.d_readdata); end
        for (int j = 0; j < 3; j++) begin
            #1;
            total++; if (bus.f_waitrequest !== 1'b1 || bus.d_waitrequest !== 1'b1) begin bad++; $display("FAIL rr_wait j=%0d got=%b/%b want=1/1", j, bus.f_waitrequest, bus.d_waitrequest); end
            total++; if (bus.mem_chipselect !== 1'b0 || bus.mem_clken !== 1'b0) begin bad++; $display("FAIL rr_mem j=%0d cs/clken got=%b/%b want=0/0", j, bus.mem_chipselect, bus.mem_clken); end
            tick();
            total++; if (bus.f_readdatavalid !== 1'b0 || bus.d_readdatavalid !== 1'b0) begin bad++; $display("FAIL rr_rdv j=%0d got=%b/%b want=0/0", j, bus.f_readdatavalid, bus.d_readdatavalid); end
        end
        bus.reset_req = 1'b0;
        #1;
        total++; if (bus.f_waitrequest !== 1'b0 || bus.d_waitrequest !== 1'b1 || bus.mem_clken !== 1'b1) begin bad++; $display("FAIL rr_resume_f got=%b/%b/%b want=0/1/1", bus.f_waitrequest, bus.d_waitrequest, bus.mem_clken); end
        tick();
        #1;
        total++; if (bus.d_waitrequest !== 1'b0 || bus.f_waitrequest !== 1'b1) begin bad++; $display("FAIL rr_resume_d got=%b/%b want=0/1", bus.d_waitrequest, bus.f_waitrequest); end
        tick();
        total++; if (bus.d_readdatavalid !== 1'b1 || bus.f_readdatavalid !== 1'b0) begin bad++; $display("FAIL rr_resume_rdv got=%b/%b want=1/0", bus.d_readdatavalid, bus.f_readdatavalid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_rw_collision();
        bus.d_read = 1'b1; bus.d_write = 1'b1;
        bus.d_address = 11'h200; bus.d_writedata = 16'h7E57; bus.d_byteenable = 2'b11;
        #1;
        total++; if (bus.mem_write !== 1'b1 || bus.mem_debugaccess !== 1'b1 || bus.d_waitrequest !== 1'b0) begin bad++; $display("FAIL rw_cmd got=%b%b%b want=110", bus.mem_write, bus.mem_debugaccess, bus.d_waitrequest); end
        tick();
        total++; if (bus.d_readdatavalid !== 1'b0) begin bad++; $display("FAIL rw_no_rdv got=%b want=0", bus.d_readdatavalid); end
        bus.d_write = 1'b0;
        tick();
        bus.d_read = 1'b0;
        total++; if (bus.d_readdatavalid !== 1'b1 || bus.d_readdata !== 16'h7E57) begin bad++; $display("FAIL rw_readback got=%b/%h want=1/7E57", bus.d_readdatavalid, bus.d_readdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_debug_write_read();
        test_byte_write();
        test_contention();
        test_reset_req();
        test_rw_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ocrom_port_arbiter.md
# ocrom_port_arbiter

Two-port Avalon-MM arbiter that shares the single-port 2048x16 instruction on-chip memory between the processor fetch master (read-only) and the debug master (read/write). It sits directly in front of the memory's s1 port, issues at most one access per cycle, and tracks the memory's one-cycle read latency to return pipelined read data to the correct requester. It also gates memory clock-enable during reset requests and generates the debug-write qualifier.

## Interface
Parameters:
- ADDR_W, 11, word address width (2048 words)
- DATA_W, 16, data width
- BE_W, 2, byteenable width (DATA_W/8)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  reset request; blocks new grants, freezes memory clock-enable
- f_address  in  ADDR_W  fetch master word address
- f_read  in  1  fetch read request
- f_waitrequest  out  1  high = fetch command not accepted this cycle
- f_readdata  out  DATA_W  fetch read data
- f_readdatavalid  out  1  fetch read data valid
- d_address  in  ADDR_W  debug master word address
- d_read  in  1  debug read request
- d_write  in  1  debug write request
- d_writedata  in  DATA_W  debug write data
- d_byteenable  in  BE_W  debug byte enables
- d_waitrequest  out  1  high = debug command not accepted this cycle
- d_readdata  out  DATA_W  debug read data
- d_readdatavalid  out  1  debug read data valid
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  BE_W  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory
- mem_debugaccess  out  1  to memory; high only for granted debug writes
- mem_clken  out  1  to memory; = ~reset_req
- mem_readdata  in  DATA_W  from memory, valid one cycle after address

## Operation
- Requests: f_req = f_read; d_req = d_read | d_write. d_read & d_write together: write takes precedence, read ignored for that command.
- Grant (combinational, per cycle): none if reset or reset_req; else single requester wins; both requesting -> master not in last_grant wins (round-robin).
- last_grant register: updated to winner on every grant; reset value = DEBUG (fetch wins first contention).
- Granted master sees waitrequest=0 that cycle; non-granted requesting master sees waitrequest=1 and must hold its command. Idle master's waitrequest = 1 (Avalon-legal, no stall since not requesting).
- Memory drive: mem_chipselect=1 on grant, mux address/writedata/byteenable from winner; fetch reads use byteenable all-ones. mem_write = mem_debugaccess = granted debug write. No grant: chipselect=0, write=0, debugaccess=0, address holds last value.
- Read tracking: registers rv_f, rv_d set on cycle after a granted fetch/debug read, cleared otherwise. f_readdatavalid=rv_f, d_readdatavalid=rv_d. f_readdata and d_readdata both = mem_readdata (consumers qualify with valid).
- Writes produce no readdatavalid.
- reset_req: mem_clken low, no new grants; a read granted the cycle before reset_req rose still returns its valid (address already latched in memory).

## Timing
- Read latency: grant cycle N -> readdatavalid at N+1, one cycle only. Back-to-back reads sustain one per cycle.
- Write: completes in grant cycle; a read of same address in cycle N+1 returns new data at N+2.
- Contention: both holding requests -> strict alternation F,D,F,D... starting with F after reset.
- Reset values: f_readdatavalid=0, d_readdatavalid=0, both waitrequest=1, mem_chipselect=0, mem_write=0, mem_debugaccess=0, mem_address=0, last_grant=DEBUG.
- Reset asserted mid-read: rv_f/rv_d cleared at next edge; pending valid is dropped.
- reset_req asserted/deasserted: takes effect same cycle (combinational gating of grant and mem_clken).

## Test plan
- After reset, f_read=1 addr 0x000 continuous: f_waitrequest=0 every cycle, f_readdatavalid from cycle 2 onward, data = ROM words 0,1,... as address increments.
- Debug write addr 0x123 data 0xBEEF be=2'b11, then debug read 0x123: mem_debugaccess=1 only in write cycle; d_readdatavalid one cycle after read grant with 0xBEEF.
- Byte write addr 0x010 data 0x12AB be=2'b01 over 0x5566: subsequent read returns 0x55AB.
- Both masters request continuously: grants alternate F,D,F,D; each waitrequest low every other cycle; valids land on correct master with no cross-routing.
- reset_req high for 3 cycles during contention: no grants, mem_clken=0, both waitrequest=1; read granted the cycle before still gives one valid; arbitration resumes with correct round-robin order.
- Simultaneous d_read and d_write to 0x200: treated as write, no d_readdatavalid.
